// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg7_pkg
// Purpose  : Shared 7-segment definitions. Holds the active-low segment
//            patterns (a..g = bit0..bit6), the symbol type and the pattern
//            decoder used by the readback monitor and the encoder bench.
// Revision : 1.0  initial release
// ============================================================================
package seg7_pkg;

    // Active-low segment patterns, bit0 = segment a ... bit6 = segment g
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Symbol kind; UNKNOWN is only ever a committed state, never a decode result
    typedef enum logic [1:0] {
        SYM_UNKNOWN = 2'd0,
        SYM_DIGIT   = 2'd1,
        SYM_BLANK   = 2'd2,
        SYM_ILLEGAL = 2'd3
    } sym_kind_e;

    // Value is only meaningful for SYM_DIGIT and is forced to 0 otherwise,
    // so whole-struct equality is symbol equality.
    typedef struct packed {
        sym_kind_e  kind;
        logic [3:0] value;
    } sym_t;

    function automatic sym_t seg7_decode(input logic [6:0] pattern);
        sym_t s;
        s.kind  = SYM_DIGIT;
        s.value = 4'd0;
        case (pattern)
            SEG_0:     s.value = 4'd0;
            SEG_1:     s.value = 4'd1;
            SEG_2:     s.value = 4'd2;
            SEG_3:     s.value = 4'd3;
            SEG_4:     s.value = 4'd4;
            SEG_5:     s.value = 4'd5;
            SEG_6:     s.value = 4'd6;
            SEG_7:     s.value = 4'd7;
            SEG_8:     s.value = 4'd8;
            SEG_9:     s.value = 4'd9;
            SEG_BLANK: s.kind  = SYM_BLANK;
            default:   s.kind  = SYM_ILLEGAL;
        endcase
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_readback_if.sv
`default_nettype none
// ============================================================================
// Module   : seg7_readback_if
// Purpose  : Sample/segment input and decoded status outputs of the
//            7-segment readback monitor. master = stimulus side,
//            slave = monitor side.
// Revision : 1.0  initial release
// ============================================================================
interface seg7_readback_if;
    logic       sample_en;
    logic [6:0] seg_in;
    logic [3:0] digit;
    logic       digit_valid;
    logic       blank;
    logic       code_err;
    logic       flashing;
    logic       update;

    modport master (
        output sample_en, seg_in,
        input  digit, digit_valid, blank, code_err, flashing, update
    );

    modport slave (
        input  sample_en, seg_in,
        output digit, digit_valid, blank, code_err, flashing, update
    );
endinterface
`default_nettype wire

// File: rtl/seg7_debounce.sv
`default_nettype none
// ============================================================================
// Module   : seg7_debounce
// Purpose  : Holds the candidate symbol and its run length. Raises a
//            combinational commit strobe on the strobe edge where the run
//            first reaches STABLE_N and the candidate differs from the
//            currently committed symbol.
// Revision : 1.0  initial release
// ============================================================================
module seg7_debounce
    import seg7_pkg::*;
#(
    parameter int STABLE_N = 4
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    input  wire logic       i_sample_en,
    input  wire sym_t       i_sym,
    input  wire sym_kind_e  i_cur_kind,
    input  wire logic [3:0] i_cur_value,
    output logic            o_commit,
    output sym_t            o_cand
);

    localparam logic [3:0] c_CNT_MAX = 4'(STABLE_N);
    localparam logic [3:0] c_CNT_PRE = 4'(STABLE_N - 1);

    sym_t       r_cand;
    logic [3:0] r_cnt;
    logic       w_same;
    logic       w_differs;

    assign w_same    = (i_sym == r_cand);
    assign w_differs = (r_cand.kind != i_cur_kind) ||
                       ((r_cand.kind == SYM_DIGIT) && (r_cand.value != i_cur_value));

    // Count only becomes STABLE_N on the edge where it was STABLE_N-1 and the
    // sample matched, so a saturated run never re-commits.
    assign o_commit = i_sample_en && w_same && (r_cnt == c_CNT_PRE) && w_differs;
    assign o_cand   = r_cand;

    // Candidate tracking: restart the run on any new symbol, otherwise extend it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cand.kind  <= SYM_UNKNOWN;
            r_cand.value <= 4'd0;
            r_cnt        <= 4'd0;
        end else if (i_sample_en) begin
            if (w_same) begin
                if (r_cnt != c_CNT_MAX) begin
                    r_cnt <= r_cnt + 4'd1;
                end
            end else begin
                r_cand <= i_sym;
                r_cnt  <= 4'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/seg7_readback.sv
`default_nettype none
// ============================================================================
// Module   : seg7_readback
// Purpose  : 7-segment readback monitor. Decodes sampled active-low segment
//            lines, debounces them, tracks the committed symbol kind, holds
//            the last digit and reports digit/blank flashing per window.
// Revision : 1.0  initial release
// ============================================================================
module seg7_readback
    import seg7_pkg::*;
#(
    parameter int STABLE_N      = 4,
    parameter int FLASH_WIN     = 64,
    parameter int FLASH_MIN_TOG = 2
) (
    input wire logic       clk,
    input wire logic       rst_n,
    seg7_readback_if.slave bus
);

    localparam logic [9:0] c_WIN_LAST = 10'(FLASH_WIN - 1);
    localparam logic [8:0] c_MIN_TOG  = 9'(FLASH_MIN_TOG);
    localparam logic [7:0] c_TOG_SAT  = 8'd255;

    sym_t       w_sym;
    sym_t       w_cand;
    logic       w_commit;
    sym_kind_e  r_state;
    sym_kind_e  w_next_state;
    logic [3:0] r_digit;
    logic       r_update;
    logic [9:0] r_win;
    logic [7:0] r_tog;
    logic       r_flashing;
    logic       w_toggle;
    logic [8:0] w_tog_total;
    logic       w_digit_valid;
    logic       w_blank;
    logic       w_code_err;

    assign w_sym = seg7_decode(bus.seg_in);

    seg7_debounce #(
        .STABLE_N (STABLE_N)
    ) u_debounce (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_sample_en (bus.sample_en),
        .i_sym       (w_sym),
        .i_cur_kind  (r_state),
        .i_cur_value (r_digit),
        .o_commit    (w_commit),
        .o_cand      (w_cand)
    );

    // Committed-kind state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= SYM_UNKNOWN;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state: any commit moves to the candidate's kind; UNKNOWN is never a candidate
    always_comb begin
        w_next_state = r_state;
        if (w_commit) begin
            w_next_state = w_cand.kind;
        end
    end

    // Status flags decoded straight from the registered state
    always_comb begin
        w_digit_valid = 1'b0;
        w_blank       = 1'b0;
        w_code_err    = 1'b0;
        case (r_state)
            SYM_DIGIT:   w_digit_valid = 1'b1;
            SYM_BLANK:   w_blank       = 1'b1;
            SYM_ILLEGAL: w_code_err    = 1'b1;
            default:     ;
        endcase
    end

    // Digit hold (only a digit commit loads it) and the one-cycle change pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_digit  <= 4'd0;
            r_update <= 1'b0;
        end else begin
            r_update <= w_commit;
            if (w_commit && (w_cand.kind == SYM_DIGIT)) begin
                r_digit <= w_cand.value;
            end
        end
    end

    // A toggle is digit->blank, or blank->the same held digit; a new value is a change
    assign w_toggle = w_commit &&
                      (((r_state == SYM_DIGIT) && (w_cand.kind == SYM_BLANK)) ||
                       ((r_state == SYM_BLANK) && (w_cand.kind == SYM_DIGIT) &&
                        (w_cand.value == r_digit)));

    // Includes a toggle landing on the wrap edge so it counts in the closing window
    assign w_tog_total = {1'b0, r_tog} + {8'd0, w_toggle};

    // Flash window: count strobes, evaluate and clear toggles on wrap
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_win      <= 10'd0;
            r_tog      <= 8'd0;
            r_flashing <= 1'b0;
        end else if (bus.sample_en) begin
            if (r_win == c_WIN_LAST) begin
                r_win      <= 10'd0;
                r_tog      <= 8'd0;
                r_flashing <= (w_tog_total >= c_MIN_TOG);
            end else begin
                r_win <= r_win + 10'd1;
                if (r_tog != c_TOG_SAT) begin
                    r_tog <= w_tog_total[7:0];
                end
            end
        end
    end

    assign bus.digit       = r_digit;
    assign bus.digit_valid = w_digit_valid;
    assign bus.blank       = w_blank;
    assign bus.code_err    = w_code_err;
    assign bus.flashing    = r_flashing;
    assign bus.update      = r_update;

endmodule
`default_nettype wire

// File: tb/tb_seg7_readback.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_readback
// Purpose  : Self-checking bench for seg7_readback. Directed scenarios plus
//            randomized segment runs compared against a history-based
//            reference model of decode, debounce, hold and flash detection.
// Revision : 1.0  initial release
// ============================================================================
module tb_seg7_readback;

    localparam int STABLE_N      = 4;
    localparam int FLASH_WIN     = 64;
    localparam int FLASH_MIN_TOG = 2;
    localparam int ID_BLANK      = 10;
    localparam int ID_ILLEGAL    = 11;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    seg7_readback_if bus_if ();

    seg7_readback #(
        .STABLE_N      (STABLE_N),
        .FLASH_WIN     (FLASH_WIN),
        .FLASH_MIN_TOG (FLASH_MIN_TOG)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [6:0] pat_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    // Reference model: symbol history, committed symbol id (-1 = unknown),
    // held digit, flash flag, toggles in the open window, strobes since reset
    int m_hist[$];
    int m_committed;
    int m_digit;
    int m_flash;
    int m_tog;
    int m_nsamp;
    int m_update;

    function automatic int ref_decode(input logic [6:0] p);
        for (int i = 0; i < 10; i++) begin
            if (p == pat_tab[i]) return i;
        end
        if (p == 7'h7F) return ID_BLANK;
        return ID_ILLEGAL;
    endfunction

    task automatic model_reset();
        m_hist.delete();
        m_committed = -1;
        m_digit     = 0;
        m_flash     = 0;
        m_tog       = 0;
        m_nsamp     = 0;
        m_update    = 0;
    endtask

    task automatic model_step(input logic [6:0] p);
        int sym;
        int run;
        int toggle;
        sym = ref_decode(p);
        m_hist.push_back(sym);
        if (m_hist.size() > 20) void'(m_hist.pop_front());
        run = 0;
        for (int i = m_hist.size() - 1; i >= 0; i--) begin
            if (m_hist[i] != sym) break;
            run++;
        end
        m_update = (run == STABLE_N) && (sym != m_committed);
        toggle = 0;
        if (m_update) begin
            if (m_committed >= 0 && m_committed < 10 && sym == ID_BLANK) toggle = 1;
            if (m_committed == ID_BLANK && sym < 10 && sym == m_digit) toggle = 1;
            if (sym < 10) m_digit = sym;
            m_committed = sym;
        end
        if ((m_nsamp % FLASH_WIN) == FLASH_WIN - 1) begin
            m_flash = ((m_tog + toggle) >= FLASH_MIN_TOG);
            m_tog   = 0;
        end else begin
            m_tog = (m_tog + toggle > 255) ? 255 : m_tog + toggle;
        end
        m_nsamp++;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string where);
        check({where, ".digit"},       int'(bus_if.digit),       m_digit);
        check({where, ".digit_valid"}, int'(bus_if.digit_valid), int'(m_committed >= 0 && m_committed < 10));
        check({where, ".blank"},       int'(bus_if.blank),       int'(m_committed == ID_BLANK));
        check({where, ".code_err"},    int'(bus_if.code_err),    int'(m_committed == ID_ILLEGAL));
        check({where, ".flashing"},    int'(bus_if.flashing),    m_flash);
        check({where, ".update"},      int'(bus_if.update),      m_update);
    endtask

    // One clock with reset low, then check everything is cleared
    task automatic do_reset(input string where);
        rst_n            = 1'b0;
        bus_if.sample_en = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        check_all(where);
        rst_n = 1'b1;
    endtask

    // One strobe with pattern p, then 'gap' idle clocks
    task automatic sample(input logic [6:0] p, input int gap, input string where);
        bus_if.seg_in    = p;
        bus_if.sample_en = 1'b1;
        @(posedge clk);
        #1;
        bus_if.sample_en = 1'b0;
        model_step(p);
        check_all(where);
        if (gap > 0) begin
            repeat (gap) @(posedge clk);
            #1;
            m_update = 0;
            check({where, ".idle_update"}, int'(bus_if.update), 0);
        end
    endtask

    initial begin
        int len;
        int sel;
        logic [6:0] p;

        bus_if.sample_en = 1'b0;
        bus_if.seg_in    = 7'h7F;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        do_reset("reset");

        // Held digit 2, strobe every 4th clock
        for (int i = 0; i < 6; i++) sample(7'b0100100, 3, "hold2");
        check("hold2.final_digit", int'(bus_if.digit), 2);

        // Glitch to 8 inside a run of 3s
        for (int i = 0; i < 3; i++) sample(7'b0110000, 0, "glitch3a");
        sample(7'b0000000, 0, "glitch8");
        for (int i = 0; i < 6; i++) sample(7'b0110000, 1, "glitch3b");
        check("glitch.final_digit", int'(bus_if.digit), 3);

        // Flash 1 / blank every 8 samples, then steady 1
        for (int i = 0; i < 128; i++) sample(((i / 8) % 2 == 0) ? 7'b1111001 : 7'b1111111, 0, "flash");
        check("flash.on", int'(bus_if.flashing), 1);
        for (int i = 0; i < 130; i++) sample(7'b1111001, 0, "steady1");
        check("flash.off", int'(bus_if.flashing), 0);

        // Illegal pattern
        for (int i = 0; i < 5; i++) sample(7'b1010101, 1, "illegal");
        check("illegal.code_err", int'(bus_if.code_err), 1);
        check("illegal.digit", int'(bus_if.digit), 1);

        // Change vs toggle: 5 -> blank -> 6
        do_reset("reset2");
        for (int i = 0; i < 5; i++) sample(7'b0010010, 0, "chg5");
        for (int i = 0; i < 5; i++) sample(7'b1111111, 0, "chgblank");
        for (int i = 0; i < 5; i++) sample(7'b0000010, 0, "chg6");
        for (int i = 0; i < 60; i++) sample(7'b0000010, 0, "chg6hold");
        check("chg.flashing", int'(bus_if.flashing), 0);
        check("chg.digit", int'(bus_if.digit), 6);

        // Reset mid-flash and mid-debounce, then a full run is needed again
        for (int i = 0; i < 40; i++) sample(((i / 5) % 2 == 0) ? 7'b0000010 : 7'b1111111, 0, "preflash");
        sample(7'b0011001, 0, "middeb");
        sample(7'b0011001, 0, "middeb");
        do_reset("reset_mid");
        for (int i = 0; i < 5; i++) sample(7'b0011001, 0, "after_rst");

        // Randomized runs of legal, blank and arbitrary patterns
        for (int r = 0; r < 120; r++) begin
            sel = $urandom_range(0, 11);
            if (sel < 10)       p = pat_tab[sel];
            else if (sel == 10) p = 7'h7F;
            else                p = 7'($urandom);
            len = $urandom_range(1, 9);
            for (int k = 0; k < len; k++) sample(p, $urandom_range(0, 3), "rand");
            if (r == 60) do_reset("reset_rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
